// File: rtl/bpsk_frame_sync_if.sv
// Byte-stream handshake between the frame synchroniser and the downstream packet stage.
interface bpsk_frame_sync_if;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_ready;
    logic       byte_first;
    logic       byte_last;

    modport master (
        output byte_data,
        output byte_valid,
        output byte_first,
        output byte_last,
        input  byte_ready
    );

    modport slave (
        input  byte_data,
        input  byte_valid,
        input  byte_first,
        input  byte_last,
        output byte_ready
    );
endinterface

// File: rtl/bpsk_frame_sync.sv
// BPSK frame synchroniser: symbol timing recovery from a hard-decision sample
// stream, sync-word hunt with 180-degree ambiguity resolution, and payload
// byte packing onto a valid/ready byte stream.
module bpsk_frame_sync #(
    parameter int                    SPS           = 16,
    parameter int                    SYNC_WIDTH    = 16,
    parameter logic [SYNC_WIDTH-1:0] SYNC_WORD     = 16'hD391,
    parameter int                    PAYLOAD_BYTES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              data_in,
    bpsk_frame_sync_if.master bus,
    output logic              locked,
    output logic              polarity_inv,
    output logic              overflow
);
    localparam int CW  = $clog2(SPS);
    localparam int OW  = $clog2(SPS + 2);
    localparam int BCW = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;

    localparam logic [CW-1:0]  CNT_MAX   = CW'(SPS - 1);
    localparam logic [CW-1:0]  CNT_HALF  = CW'(SPS / 2);
    localparam logic [BCW-1:0] BYTE_LAST = BCW'(PAYLOAD_BYTES - 1);

    typedef enum logic {HUNT, PAYLOAD} state_t;

    // ---------------- symbol timing and decision ----------------
    logic          prev_in_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [OW-1:0] ones_q, ones_d;
    logic          sym_q, sym_d;
    logic          strobe_q, strobe_d;
    logic [OW-1:0] ones_total;
    logic [OW:0]   ones_twice;
    logic          trans;

    // Counter adjust on transitions, majority accumulation and symbol decision.
    always_comb begin
        trans      = (data_in != prev_in_q);
        ones_total = ones_q + OW'(data_in);
        ones_twice = {ones_total, 1'b0};
        cnt_d      = cnt_q + CW'(1);
        ones_d     = ones_total;
        sym_d      = sym_q;
        strobe_d   = 1'b0;
        if (cnt_q == CNT_MAX) begin
            // Decision cycle always closes the symbol; a late edge here is
            // absorbed by the next symbol's tracking rather than a second decision.
            cnt_d    = '0;
            sym_d    = (ones_twice > (OW+1)'(SPS));
            ones_d   = '0;
            strobe_d = 1'b1;
        end else if (trans && (cnt_q != '0) && (cnt_q < CNT_HALF)) begin
            // Edge arrived early in the window: we are ahead, stretch by one.
            cnt_d = cnt_q;
        end else if (trans && (cnt_q >= CNT_HALF)) begin
            // Edge arrived late: skip ahead, but never wrap past the decision point.
            cnt_d = (cnt_q >= CNT_MAX - CW'(1)) ? CNT_MAX : cnt_q + CW'(2);
        end
    end

    // Timing state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_in_q <= 1'b0;
            cnt_q     <= '0;
            ones_q    <= '0;
            sym_q     <= 1'b0;
            strobe_q  <= 1'b0;
        end else begin
            prev_in_q <= data_in;
            cnt_q     <= cnt_d;
            ones_q    <= ones_d;
            sym_q     <= sym_d;
            strobe_q  <= strobe_d;
        end
    end

    // ---------------- frame FSM and byte packing ----------------
    state_t                state_q, state_d;
    logic [SYNC_WIDTH-1:0] sr_q, sr_d, sr_next;
    logic                  pol_q, pol_d;
    logic [7:0]            bsr_q, bsr_d;
    logic [2:0]            bit_q, bit_d;
    logic [BCW-1:0]        bcnt_q, bcnt_d;
    logic                  byte_done;
    logic [7:0]            byte_new;
    logic                  first_new, last_new;

    // Sync hunt, payload shifting and frame length bookkeeping, per symbol strobe.
    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        pol_d     = pol_q;
        bsr_d     = bsr_q;
        bit_d     = bit_q;
        bcnt_d    = bcnt_q;
        byte_done = 1'b0;
        sr_next   = {sr_q[SYNC_WIDTH-2:0], sym_q};
        byte_new  = {bsr_q[6:0], sym_q ^ pol_q};
        first_new = (bcnt_q == '0);
        last_new  = (bcnt_q == BYTE_LAST);
        if (strobe_q) begin
            case (state_q)
                HUNT: begin
                    sr_d = sr_next;
                    if (sr_next == SYNC_WORD) begin
                        state_d = PAYLOAD;
                        pol_d   = 1'b0;
                    end else if (sr_next == ~SYNC_WORD) begin
                        state_d = PAYLOAD;
                        pol_d   = 1'b1;
                    end
                end
                PAYLOAD: begin
                    bsr_d = byte_new;
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        byte_done = 1'b1;
                        bcnt_d    = bcnt_q + BCW'(1);
                        if (last_new) begin
                            // Frame over: demand a whole fresh sync word.
                            bcnt_d  = '0;
                            state_d = HUNT;
                            sr_d    = '0;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // Frame state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= HUNT;
            sr_q    <= '0;
            pol_q   <= 1'b0;
            bsr_q   <= '0;
            bit_q   <= '0;
            bcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            pol_q   <= pol_d;
            bsr_q   <= bsr_d;
            bit_q   <= bit_d;
            bcnt_q  <= bcnt_d;
        end
    end

    // ---------------- output holding register ----------------
    logic [7:0] bdata_q, bdata_d;
    logic       bvalid_q, bvalid_d;
    logic       bfirst_q, bfirst_d;
    logic       blast_q, blast_d;
    logic       ovf_q, ovf_d;

    // Load completed bytes, hold under backpressure, drop when still occupied.
    always_comb begin
        bdata_d  = bdata_q;
        bvalid_d = bvalid_q;
        bfirst_d = bfirst_q;
        blast_d  = blast_q;
        ovf_d    = 1'b0;
        if (byte_done) begin
            if (bvalid_q && !bus.byte_ready) begin
                ovf_d = 1'b1;
            end else begin
                // A handshake in the same cycle frees the slot, so the new byte wins.
                bdata_d  = byte_new;
                bvalid_d = 1'b1;
                bfirst_d = first_new;
                blast_d  = last_new;
            end
        end else if (bvalid_q && bus.byte_ready) begin
            bvalid_d = 1'b0;
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bdata_q  <= '0;
            bvalid_q <= 1'b0;
            bfirst_q <= 1'b0;
            blast_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            bdata_q  <= bdata_d;
            bvalid_q <= bvalid_d;
            bfirst_q <= bfirst_d;
            blast_q  <= blast_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.byte_data  = bdata_q;
    assign bus.byte_valid = bvalid_q;
    assign bus.byte_first = bfirst_q;
    assign bus.byte_last  = blast_q;
    assign locked         = (state_q == PAYLOAD);
    assign polarity_inv   = pol_q;
    assign overflow       = ovf_q;
endmodule
